// File: rtl/apmu_ibex_pkg.sv
// Shared APMU/Ibex types: PMP access kinds, privilege levels and the
// channel-arbiter FSM encoding.
package apmu_ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CHECK = 2'd1,
        ARB_RESP  = 2'd2
    } arb_fsm_e;

    // Plain constants so the state register can stay a simple vector.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/apmu_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// registered pointer; the pointer moves past the winner when the grant is taken.
module apmu_rr_arbiter #(
    parameter int N   = 4,
    parameter int IdW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic           accept_i,
    output logic [N-1:0]   grant_o,
    output logic [IdW-1:0] idx_o,
    output logic           valid_o
);

    logic [IdW-1:0] r_ptr;
    logic [IdW:0]   w_sum;
    logic [IdW-1:0] w_pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IdW+1)'(k);
            if (w_sum >= (IdW+1)'(N)) begin
                w_sum = w_sum - (IdW+1)'(N);
            end
            w_pos = w_sum[IdW-1:0];
            if (!valid_o && req_i[w_pos]) begin
                valid_o        = 1'b1;
                idx_o          = w_pos;
                grant_o[w_pos] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (accept_i && valid_o) begin
            r_ptr <= (idx_o == IdW'(N-1)) ? '0 : idx_o + IdW'(1);
        end
    end

endmodule

// File: rtl/apmu_pmp_chan_arbiter.sv
// Shares one PMP checking channel between NumReq requesters, returns the
// sampled error over a response handshake and keeps a first-fault log.
module apmu_pmp_chan_arbiter
    import apmu_ibex_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int CntWidth = 16,
    parameter int IdWidth  = $clog2(NumReq)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq-1:0][33:0]    req_addr_i,
    input  pmp_req_e [NumReq-1:0]      req_type_i,
    input  priv_lvl_e [NumReq-1:0]     req_priv_i,
    output logic [NumReq-1:0]          rsp_valid_o,
    input  logic [NumReq-1:0]          rsp_ready_i,
    output logic                       rsp_err_o,
    input  logic                       cfg_update_i,
    output logic [33:0]                pmp_req_addr_o,
    output pmp_req_e                   pmp_req_type_o,
    output priv_lvl_e                  pmp_priv_o,
    input  logic                       pmp_req_err_i,
    output logic                       fault_valid_o,
    output logic [33:0]                fault_addr_o,
    output pmp_req_e                   fault_type_o,
    output logic [IdWidth-1:0]         fault_id_o,
    input  logic                       fault_clr_i,
    output logic [CntWidth-1:0]        fault_cnt_o
);

    logic [1:0]          r_state;
    logic [33:0]         r_addr;
    pmp_req_e            r_type;
    priv_lvl_e           r_priv;
    logic [IdWidth-1:0]  r_id;
    logic                r_err;
    logic                r_fault_valid;
    logic [33:0]         r_fault_addr;
    pmp_req_e            r_fault_type;
    logic [IdWidth-1:0]  r_fault_id;
    logic [CntWidth-1:0] r_fault_cnt;

    logic [NumReq-1:0]   w_grant;
    logic [IdWidth-1:0]  w_gnt_idx;
    logic                w_gnt_valid;
    logic                w_accept;
    logic                w_commit;
    logic                w_fault_evt;

    assign w_accept    = (r_state == ST_IDLE) && w_gnt_valid;
    // The check result is committed only on a CHECK cycle without a cfg write.
    assign w_commit    = (r_state == ST_CHECK) && !cfg_update_i;
    assign w_fault_evt = w_commit && pmp_req_err_i;

    apmu_rr_arbiter #(
        .N   (NumReq),
        .IdW (IdWidth)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_valid_i),
        .accept_i (w_accept),
        .grant_o  (w_grant),
        .idx_o    (w_gnt_idx),
        .valid_o  (w_gnt_valid)
    );

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
        assign req_ready_o[gi] = w_grant[gi] && (r_state == ST_IDLE) && !rst_i;
        assign rsp_valid_o[gi] = (r_state == ST_RESP) && (r_id == IdWidth'(gi));
    end

    assign rsp_err_o      = (r_state == ST_RESP) && r_err;
    assign pmp_req_addr_o = r_addr;
    assign pmp_req_type_o = r_type;
    assign pmp_priv_o     = r_priv;
    assign fault_valid_o  = r_fault_valid;
    assign fault_addr_o   = r_fault_addr;
    assign fault_type_o   = r_fault_type;
    assign fault_id_o     = r_fault_id;
    assign fault_cnt_o    = r_fault_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_type  <= PMP_ACC_READ;
            r_priv  <= PRIV_LVL_M;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_addr  <= req_addr_i[w_gnt_idx];
                        r_type  <= req_type_i[w_gnt_idx];
                        r_priv  <= req_priv_i[w_gnt_idx];
                        r_id    <= w_gnt_idx;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_commit) begin
                        r_err   <= pmp_req_err_i;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[r_id]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= '0;
            r_fault_type  <= PMP_ACC_EXEC;
            r_fault_id    <= '0;
            r_fault_cnt   <= '0;
        end else if (w_fault_evt) begin
            // A clear in the same cycle makes this fault the new first fault.
            if (!r_fault_valid || fault_clr_i) begin
                r_fault_addr <= r_addr;
                r_fault_type <= r_type;
                r_fault_id   <= r_id;
            end
            r_fault_valid <= 1'b1;
            if (fault_clr_i) begin
                r_fault_cnt <= CntWidth'(1);
            end else if (r_fault_cnt != {CntWidth{1'b1}}) begin
                r_fault_cnt <= r_fault_cnt + CntWidth'(1);
            end
        end else if (fault_clr_i) begin
            r_fault_valid <= 1'b0;
            r_fault_cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_apmu_pmp_chan_arbiter.sv
// Directed bench for the PMP channel arbiter; a second instance with a
// 2-bit counter shares all inputs to observe saturation.
module tb_apmu_pmp_chan_arbiter;
    import apmu_ibex_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0]        req_valid_i;
    logic [3:0]        req_ready_o;
    logic [3:0][33:0]  req_addr_i;
    pmp_req_e [3:0]    req_type_i;
    priv_lvl_e [3:0]   req_priv_i;
    logic [3:0]        rsp_valid_o;
    logic [3:0]        rsp_ready_i;
    logic              rsp_err_o;
    logic              cfg_update_i;
    logic [33:0]       pmp_req_addr_o;
    pmp_req_e          pmp_req_type_o;
    priv_lvl_e         pmp_priv_o;
    logic              pmp_req_err_i;
    logic              fault_valid_o;
    logic [33:0]       fault_addr_o;
    pmp_req_e          fault_type_o;
    logic [1:0]        fault_id_o;
    logic              fault_clr_i;
    logic [15:0]       fault_cnt_o;

    logic [3:0]        s_req_ready;
    logic [3:0]        s_rsp_valid;
    logic              s_rsp_err;
    logic [33:0]       s_pmp_addr;
    pmp_req_e          s_pmp_type;
    priv_lvl_e         s_pmp_priv;
    logic              s_fault_valid;
    logic [33:0]       s_fault_addr;
    pmp_req_e          s_fault_type;
    logic [1:0]        s_fault_id;
    logic [1:0]        s_fault_cnt;

    int errs   = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    apmu_pmp_chan_arbiter #(.NumReq(4), .CntWidth(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_type_i(req_type_i), .req_priv_i(req_priv_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_err_o(rsp_err_o),
        .cfg_update_i(cfg_update_i),
        .pmp_req_addr_o(pmp_req_addr_o), .pmp_req_type_o(pmp_req_type_o),
        .pmp_priv_o(pmp_priv_o), .pmp_req_err_i(pmp_req_err_i),
        .fault_valid_o(fault_valid_o), .fault_addr_o(fault_addr_o),
        .fault_type_o(fault_type_o), .fault_id_o(fault_id_o),
        .fault_clr_i(fault_clr_i), .fault_cnt_o(fault_cnt_o)
    );

    apmu_pmp_chan_arbiter #(.NumReq(4), .CntWidth(2)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(s_req_ready),
        .req_addr_i(req_addr_i), .req_type_i(req_type_i), .req_priv_i(req_priv_i),
        .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready_i), .rsp_err_o(s_rsp_err),
        .cfg_update_i(cfg_update_i),
        .pmp_req_addr_o(s_pmp_addr), .pmp_req_type_o(s_pmp_type),
        .pmp_priv_o(s_pmp_priv), .pmp_req_err_i(pmp_req_err_i),
        .fault_valid_o(s_fault_valid), .fault_addr_o(s_fault_addr),
        .fault_type_o(s_fault_type), .fault_id_o(s_fault_id),
        .fault_clr_i(fault_clr_i), .fault_cnt_o(s_fault_cnt)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one request from IDLE through CHECK; returns in the RESP cycle.
    task automatic issue(input int id, input logic [33:0] addr, input pmp_req_e t,
                         input logic err);
        req_valid_i     = '0;
        req_valid_i[id] = 1'b1;
        req_addr_i[id]  = addr;
        req_type_i[id]  = t;
        req_priv_i[id]  = PRIV_LVL_U;
        cyc();
        req_valid_i   = '0;
        pmp_req_err_i = err;
        cyc();
        pmp_req_err_i = 1'b0;
        $display("txn: id=%0d addr=%h type=%0d err=%0b", id, addr, t, err);
    endtask

    task automatic finish_rsp(input int id);
        rsp_ready_i[id] = 1'b1;
        cyc();
        rsp_ready_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 4'hf;
        cyc();
        #1;
        checks++; if (req_ready_o !== 4'h0) begin errs++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
        checks++; if (rsp_valid_o !== 4'h0 || rsp_err_o !== 1'b0) begin errs++; $display("FAIL reset_rsp: got %b/%b want 0000/0", rsp_valid_o, rsp_err_o); end
        checks++; if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ || pmp_priv_o !== PRIV_LVL_M) begin
            errs++; $display("FAIL reset_pmp: got %h/%0d/%0d want 0/READ/M", pmp_req_addr_o, pmp_req_type_o, pmp_priv_o); end
        checks++; if (fault_valid_o !== 1'b0 || fault_cnt_o !== 16'h0 || fault_addr_o !== 34'h0 || fault_id_o !== 2'd0) begin
            errs++; $display("FAIL reset_fault: got v=%b cnt=%0d addr=%h id=%0d want all 0", fault_valid_o, fault_cnt_o, fault_addr_o, fault_id_o); end
        req_valid_i = '0;
        rst_i = 1'b0;
        cyc();
        $display("txn: reset released");
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        for (int r = 0; r < 4; r++) begin
            req_addr_i[r] = 34'(32'h100 * r);
            req_type_i[r] = PMP_ACC_READ;
            req_priv_i[r] = PRIV_LVL_S;
        end
        req_valid_i   = 4'hf;
        rsp_ready_i   = 4'hf;
        pmp_req_err_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready_o !== 4'(1 << exp_id[i])) begin errs++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready_o, 4'(1 << exp_id[i])); end
            cyc();
            checks++; if (req_ready_o !== 4'h0 || pmp_req_addr_o !== 34'(32'h100 * exp_id[i])) begin
                errs++; $display("FAIL rr_check%0d: ready=%b addr=%h want 0000/%h", i, req_ready_o, pmp_req_addr_o, 34'(32'h100 * exp_id[i])); end
            cyc();
            checks++; if (rsp_valid_o !== 4'(1 << exp_id[i]) || req_ready_o !== 4'h0) begin
                errs++; $display("FAIL rr_rsp%0d: rsp=%b ready=%b want %b/0000", i, rsp_valid_o, req_ready_o, 4'(1 << exp_id[i])); end
            cyc();
            $display("txn: rr grant %0d to id %0d", i, exp_id[i]);
        end
        req_valid_i = '0;
        rsp_ready_i = '0;
        cyc();
    endtask

    task automatic test_single();
        req_valid_i   = 4'b0010;
        req_addr_i[1] = 34'h0_8000_0000;
        req_type_i[1] = PMP_ACC_READ;
        req_priv_i[1] = PRIV_LVL_U;
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin errs++; $display("FAIL single_ready: got %b want 0010", req_ready_o); end
        cyc();
        req_valid_i = '0;
        #1;
        checks++; if (rsp_valid_o !== 4'h0) begin errs++; $display("FAIL single_t1: rsp got %b want 0000", rsp_valid_o); end
        checks++; if (pmp_req_addr_o !== 34'h0_8000_0000 || pmp_req_type_o !== PMP_ACC_READ || pmp_priv_o !== PRIV_LVL_U) begin
            errs++; $display("FAIL single_pmp: got %h/%0d/%0d", pmp_req_addr_o, pmp_req_type_o, pmp_priv_o); end
        cyc();
        checks++; if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b0 || fault_cnt_o !== 16'd0) begin
            errs++; $display("FAIL single_t2: rsp=%b err=%b cnt=%0d want 0010/0/0", rsp_valid_o, rsp_err_o, fault_cnt_o); end
        finish_rsp(1);
        checks++; if (rsp_valid_o !== 4'h0) begin errs++; $display("FAIL single_done: rsp got %b want 0000", rsp_valid_o); end
        $display("txn: single id 1 done");
    endtask

    task automatic test_fault();
        issue(2, 34'h0_0000_1000, PMP_ACC_WRITE, 1'b1);
        checks++; if (rsp_valid_o !== 4'b0100 || rsp_err_o !== 1'b1) begin errs++; $display("FAIL fault_rsp: rsp=%b err=%b want 0100/1", rsp_valid_o, rsp_err_o); end
        checks++; if (fault_valid_o !== 1'b1 || fault_addr_o !== 34'h0_0000_1000 || fault_id_o !== 2'd2 || fault_type_o !== PMP_ACC_WRITE) begin
            errs++; $display("FAIL fault_log: v=%b addr=%h id=%0d type=%0d want 1/1000/2/WRITE", fault_valid_o, fault_addr_o, fault_id_o, fault_type_o); end
        checks++; if (fault_cnt_o !== 16'd1 || s_fault_cnt !== 2'd1) begin errs++; $display("FAIL fault_cnt1: got %0d/%0d want 1/1", fault_cnt_o, s_fault_cnt); end
        finish_rsp(2);
        issue(0, 34'h0_0000_2000, PMP_ACC_READ, 1'b1);
        checks++; if (fault_addr_o !== 34'h0_0000_1000 || fault_id_o !== 2'd2 || fault_type_o !== PMP_ACC_WRITE) begin
            errs++; $display("FAIL fault_keep: addr=%h id=%0d type=%0d want 1000/2/WRITE", fault_addr_o, fault_id_o, fault_type_o); end
        checks++; if (fault_cnt_o !== 16'd2 || s_fault_cnt !== 2'd2) begin errs++; $display("FAIL fault_cnt2: got %0d/%0d want 2/2", fault_cnt_o, s_fault_cnt); end
        finish_rsp(0);
    endtask

    task automatic test_cfg_update();
        req_valid_i   = 4'b1000;
        req_addr_i[3] = 34'h0_0000_5000;
        req_type_i[3] = PMP_ACC_READ;
        cyc();
        req_valid_i = '0;
        for (int c = 0; c < 3; c++) begin
            cfg_update_i  = (c < 2);
            pmp_req_err_i = (c == 0);
            #1;
            checks++; if (rsp_valid_o !== 4'h0) begin errs++; $display("FAIL cfg_wait%0d: rsp got %b want 0000", c, rsp_valid_o); end
            cyc();
        end
        cfg_update_i  = 1'b0;
        pmp_req_err_i = 1'b0;
        checks++; if (rsp_valid_o !== 4'b1000 || rsp_err_o !== 1'b0 || fault_cnt_o !== 16'd2) begin
            errs++; $display("FAIL cfg_rsp: rsp=%b err=%b cnt=%0d want 1000/0/2", rsp_valid_o, rsp_err_o, fault_cnt_o); end
        finish_rsp(3);
        $display("txn: cfg-update access id 3 done");
    endtask

    task automatic test_backpressure();
        issue(1, 34'h0_0000_4000, PMP_ACC_EXEC, 1'b1);
        req_valid_i = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b1 || req_ready_o !== 4'h0 || pmp_req_addr_o !== 34'h0_0000_4000) begin
                errs++; $display("FAIL bp_hold%0d: rsp=%b err=%b ready=%b addr=%h", c, rsp_valid_o, rsp_err_o, req_ready_o, pmp_req_addr_o); end
            cyc();
        end
        req_valid_i = '0;
        checks++; if (fault_cnt_o !== 16'd3 || s_fault_cnt !== 2'd3 || fault_id_o !== 2'd2) begin
            errs++; $display("FAIL bp_cnt: cnt=%0d/%0d id=%0d want 3/3/2", fault_cnt_o, s_fault_cnt, fault_id_o); end
        finish_rsp(1);
        checks++; if (rsp_valid_o !== 4'h0) begin errs++; $display("FAIL bp_done: rsp got %b want 0000", rsp_valid_o); end
    endtask

    task automatic test_clear_with_fault();
        req_valid_i   = 4'b1000;
        req_addr_i[3] = 34'h0_0000_3000;
        req_type_i[3] = PMP_ACC_READ;
        cyc();
        req_valid_i   = '0;
        pmp_req_err_i = 1'b1;
        fault_clr_i   = 1'b1;
        cyc();
        pmp_req_err_i = 1'b0;
        fault_clr_i   = 1'b0;
        checks++; if (fault_valid_o !== 1'b1 || fault_addr_o !== 34'h0_0000_3000 || fault_id_o !== 2'd3 || fault_type_o !== PMP_ACC_READ) begin
            errs++; $display("FAIL clrflt_log: v=%b addr=%h id=%0d type=%0d want 1/3000/3/READ", fault_valid_o, fault_addr_o, fault_id_o, fault_type_o); end
        checks++; if (fault_cnt_o !== 16'd1 || s_fault_cnt !== 2'd1) begin errs++; $display("FAIL clrflt_cnt: got %0d/%0d want 1/1", fault_cnt_o, s_fault_cnt); end
        finish_rsp(3);
        $display("txn: clear with fault id 3 done");
    endtask

    task automatic test_saturate();
        fault_clr_i = 1'b1;
        cyc();
        fault_clr_i = 1'b0;
        checks++; if (fault_valid_o !== 1'b0 || fault_cnt_o !== 16'd0 || s_fault_cnt !== 2'd0) begin
            errs++; $display("FAIL clr_only: v=%b cnt=%0d/%0d want 0/0/0", fault_valid_o, fault_cnt_o, s_fault_cnt); end
        for (int f = 0; f < 5; f++) begin
            issue(0, 34'(32'h7000 + 32'h10 * f), PMP_ACC_WRITE, 1'b1);
            finish_rsp(0);
        end
        checks++; if (s_fault_cnt !== 2'd3 || fault_cnt_o !== 16'd5) begin errs++; $display("FAIL sat_cnt: got %0d/%0d want 3/5", s_fault_cnt, fault_cnt_o); end
        checks++; if (fault_addr_o !== 34'h0_0000_7000 || s_fault_addr !== 34'h0_0000_7000) begin
            errs++; $display("FAIL sat_first: got %h/%h want 7000", fault_addr_o, s_fault_addr); end
    endtask

    task automatic test_reset_mid();
        issue(1, 34'h2_0000_0040, PMP_ACC_READ, 1'b1);
        req_valid_i = 4'b0001;
        #1;
        checks++; if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b1) begin errs++; $display("FAIL rstmid_pre: rsp=%b err=%b want 0010/1", rsp_valid_o, rsp_err_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (rsp_valid_o !== 4'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 4'h0) begin
            errs++; $display("FAIL rstmid_hs: rsp=%b err=%b ready=%b want 0000/0/0000", rsp_valid_o, rsp_err_o, req_ready_o); end
        checks++; if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ || pmp_priv_o !== PRIV_LVL_M) begin
            errs++; $display("FAIL rstmid_pmp: got %h/%0d/%0d want 0/READ/M", pmp_req_addr_o, pmp_req_type_o, pmp_priv_o); end
        checks++; if (fault_valid_o !== 1'b0 || fault_cnt_o !== 16'd0 || s_fault_cnt !== 2'd0) begin
            errs++; $display("FAIL rstmid_fault: v=%b cnt=%0d/%0d want 0/0/0", fault_valid_o, fault_cnt_o, s_fault_cnt); end
        req_valid_i = '0;
        rsp_ready_i = 4'hf;
        cyc();
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (rsp_valid_o !== 4'h0) begin errs++; $display("FAIL rstmid_after%0d: rsp got %b want 0000", c, rsp_valid_o); end
        end
        rsp_ready_i = '0;
        $display("txn: reset during RESP done");
    endtask

    initial begin
        rst_i         = 1'b1;
        req_valid_i   = '0;
        rsp_ready_i   = '0;
        cfg_update_i  = 1'b0;
        pmp_req_err_i = 1'b0;
        fault_clr_i   = 1'b0;
        for (int r = 0; r < 4; r++) begin
            req_addr_i[r] = '0;
            req_type_i[r] = PMP_ACC_READ;
            req_priv_i[r] = PRIV_LVL_M;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_fault();
        test_cfg_update();
        test_backpressure();
        test_clear_with_fault();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/apmu_pmp_chan_arbiter.md
Name: apmu_pmp_chan_arbiter

Overview:
Shares one PMP access-checking channel between NumReq requesters, e.g. a DMA engine, a debug module and core-side masters. It does round-robin arbitration and registers the winning request onto the channel. It samples the channel's combinational error result and returns it to the requester over a valid/ready response handshake. It also keeps a sticky first-fault log and a saturating fault counter for the APMU.

Parameters:
NumReq, 4, number of requesters (2..8)
CntWidth, 16, width of the saturating fault counter
IdWidth, $clog2(NumReq), derived; width of requester index

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  [NumReq]  request valid per requester
req_ready_o  out  [NumReq]  request accepted, one-hot or zero
req_addr_i  in  [NumReq] x 34  physical address
req_type_i  in  [NumReq] x pmp_req_e  access type
req_priv_i  in  [NumReq] x priv_lvl_e  privilege of the access
rsp_valid_o  out  [NumReq]  response valid, one-hot or zero
rsp_ready_i  in  [NumReq]  requester accepts response
rsp_err_o  out  1  PMP error for the current response (shared)
cfg_update_i  in  1  PMP cfg/addr CSR write this cycle
pmp_req_addr_o  out  34  to PMP channel
pmp_req_type_o  out  pmp_req_e  to PMP channel
pmp_priv_o  out  priv_lvl_e  to PMP channel
pmp_req_err_i  in  1  combinational result from PMP channel
fault_valid_o  out  1  sticky fault logged
fault_addr_o  out  34  first faulting address
fault_type_o  out  pmp_req_e  first faulting type
fault_id_o  out  IdWidth  first faulting requester
fault_clr_i  in  1  clear fault log and counter
fault_cnt_o  out  CntWidth  saturating fault count

Behaviour:
- FSM states: IDLE, CHECK, RESP. Reset state: IDLE.
- Reset values: all ready/valid outputs 0; pmp_* outputs 0 / PMP_ACC_READ / PRIV_LVL_M; fault_* 0; counter 0; round-robin pointer 0.
- IDLE:
  - req_ready_o is combinational: one-hot grant to the first valid requester at or above the pointer, wrapping.
  - On grant g, register addr/type/priv/id and move the pointer to g+1 mod NumReq.
  - Next state: CHECK. With no valid request, stay in IDLE.
- CHECK:
  - pmp_* outputs are driven from the registered request and stay stable through CHECK and RESP.
  - If cfg_update_i=1: stay in CHECK for one more cycle (re-evaluate against the new config). Repeated updates extend CHECK indefinitely.
  - Otherwise: capture err_q <= pmp_req_err_i, then go to RESP.
- RESP:
  - rsp_valid_o[id]=1 and rsp_err_o=err_q, held until rsp_ready_i[id]; then go to IDLE.
  - cfg_update_i has no effect here (the result is already committed).
  - rsp_err_o=0 whenever no response is valid.
- Latency:
  - Accept at cycle T, then rsp_valid at T+2 at the earliest.
  - Best throughput is 1 access per 3 cycles; no grant while CHECK or RESP.
- Fault log: updated at the CHECK->RESP transition when pmp_req_err_i=1.
  - The counter increments, saturating at all-ones.
  - If fault_valid_o=0, capture addr/type/id and set fault_valid_o.
  - fault_clr_i zeroes valid and counter.
  - A clear and a new fault in the same cycle: the new fault is captured and the counter becomes 1.
- Requester rules:
  - A requester that drops req_valid_i before ready is not an error; arbitration is re-evaluated each cycle.
  - req_*_i of non-granted requesters are ignored.
- Reset mid-operation aborts any access; no response is delivered.

Decomposition:
- Add an fsm enum to apmu_ibex_pkg.
- Reuse the existing pmp_req_e / priv_lvl_e types.
- One sub-module, apmu_rr_arbiter (parameter N): combinational one-hot grant plus registered pointer, update on grant-accept.

Test Plan:
- Single requester 1, addr 34'h0_8000_0000, READ, PMP err=0: ready at T, rsp_valid_o=4'b0010 at T+2, rsp_err_o=0, fault_cnt_o=0.
- All 4 requesters held valid continuously: grant order 0,1,2,3,0, with each response accepted the same cycle it is valid; grants 3 cycles apart.
- PMP err=1 on id 2, addr 34'h0_0000_1000, WRITE: rsp_err_o=1, fault_valid_o=1, fault_addr_o=34'h0_0000_1000, fault_id_o=2, fault_cnt_o=1.
  - A second fault from id 0: log unchanged, fault_cnt_o=2.
- cfg_update_i asserted for 2 cycles during CHECK, with err changing from 1 to 0 on the second cycle: rsp_valid at T+4, rsp_err_o=0.
- rsp_ready_i held low for 5 cycles: rsp_valid_o and rsp_err_o stable, no new grants.
  - fault_clr_i together with a new fault: fault_valid_o=1, new addr captured, fault_cnt_o=1.
- CntWidth=2 with 5 faults gives fault_cnt_o=3.
  - rst_i asserted during RESP: all outputs return to reset values the same cycle, the FSM goes to IDLE, and no response is delivered.
